// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter:
// FSM state encoding and the digit-count helper used for elaboration checks.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Decimal digits needed for the largest magnitude a BIN_W-bit operand can carry.
  function automatic int min_digits(input int bin_w, input int is_signed);
    longint unsigned max_v;
    int d;
    if (is_signed != 0) begin
      max_v = 64'd1 << (bin_w - 1);
    end else begin
      max_v = (64'd1 << bin_w) - 64'd1;
    end
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (max_v >= 64'd10) begin
        max_v = max_v / 64'd10;
        d     = d + 1;
      end else begin
        d     = d;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Per-digit conditional add; no carry leaves the nibble.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end else begin
      adjusted = digit;
    end
  end

endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with valid/ready on both sides and optional two's-complement input.
module bin2bcd_iter
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
    $error("bin2bcd_iter: BIN_W must lie in 4..32");
  end
  if (DIGITS < min_digits(BIN_W, SIGNED)) begin : g_bad_digits
    $error("bin2bcd_iter: DIGITS too small for BIN_W");
  end

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [BIN_W-1:0]   sr_r;
  logic [ACC_W-1:0]   acc_r;
  logic               sign_r;
  logic [ACC_W-1:0]   bcd_r;
  logic               sign_out_r;
  logic [ACC_W-1:0]   acc_adj_s;
  logic [ACC_W-1:0]   acc_shift_s;
  logic [BIN_W-1:0]   mag_s;
  logic               neg_s;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_add3 u_add3 (
      .digit    (acc_r[4*d +: 4]),
      .adjusted (acc_adj_s[4*d +: 4])
    );
  end

  // One iteration: corrected accumulator shifted left, taking the operand MSB.
  assign acc_shift_s = {acc_adj_s[ACC_W-2:0], sr_r[BIN_W-1]};

  // Operand magnitude; the most negative value maps onto 2^(BIN_W-1), which still fits.
  always_comb begin
    mag_s = bin_in;
    neg_s = 1'b0;
    if (SIGNED != 0 && bin_in[BIN_W-1]) begin
      mag_s = ~bin_in + BIN_W'(1);
      neg_s = 1'b1;
    end else begin
      mag_s = bin_in;
      neg_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle iteration and result capture on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      sr_r       <= {BIN_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      sign_r     <= 1'b0;
      bcd_r      <= {ACC_W{1'b0}};
      sign_out_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            sr_r   <= mag_s;
            sign_r <= neg_s;
            acc_r  <= {ACC_W{1'b0}};
            cnt_r  <= CNT_W'(BIN_W - 1);
          end
        end
        ST_SHIFT: begin
          acc_r <= acc_shift_s;
          sr_r  <= {sr_r[BIN_W-2:0], 1'b0};
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == {CNT_W{1'b0}}) begin
            bcd_r      <= acc_shift_s;
            sign_out_r <= (SIGNED != 0) ? sign_r : 1'b0;
          end
        end
        ST_DONE: begin
          bcd_r      <= bcd_r;
          sign_out_r <= sign_out_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Handshake flags come straight from the state register.
  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign bcd_out   = bcd_r;
  assign sign_out  = sign_out_r;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Directed and randomised self-checking bench for bin2bcd_iter across
// four parameterisations sharing one clock and reset.
module tb_bin2bcd_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv0, iv1, iv2, iv3;
  logic        or0, or1, or2, or3;
  logic [7:0]  bin0, bin1;
  logic [15:0] bin2;
  logic [11:0] bin3;
  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic [11:0] bcd0, bcd1;
  logic [19:0] bcd2;
  logic [15:0] bcd3;
  logic        sg0, sg1, sg2, sg3;

  int n_checks = 0;
  int n_pass   = 0;

  bin2bcd_iter #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .bin_in(bin0),
    .out_valid(ov0), .out_ready(or0), .bcd_out(bcd0), .sign_out(sg0));
  bin2bcd_iter #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .bin_in(bin1),
    .out_valid(ov1), .out_ready(or1), .bcd_out(bcd1), .sign_out(sg1));
  bin2bcd_iter #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .bin_in(bin2),
    .out_valid(ov2), .out_ready(or2), .bcd_out(bcd2), .sign_out(sg2));
  bin2bcd_iter #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_u12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .bin_in(bin3),
    .out_valid(ov3), .out_ready(or3), .bcd_out(bcd3), .sign_out(sg3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int idx, input logic v, input logic [15:0] d);
    case (idx)
      0: begin iv0 = v; bin0 = d[7:0];  end
      1: begin iv1 = v; bin1 = d[7:0];  end
      2: begin iv2 = v; bin2 = d;       end
      default: begin iv3 = v; bin3 = d[11:0]; end
    endcase
  endtask

  task automatic set_ordy(input int idx, input logic r);
    case (idx)
      0: or0 = r;
      1: or1 = r;
      2: or2 = r;
      default: or3 = r;
    endcase
  endtask

  function automatic logic ir_of(input int idx);
    case (idx)
      0: return ir0;
      1: return ir1;
      2: return ir2;
      default: return ir3;
    endcase
  endfunction

  function automatic logic ov_of(input int idx);
    case (idx)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  function automatic logic sg_of(input int idx);
    case (idx)
      0: return sg0;
      1: return sg1;
      2: return sg2;
      default: return sg3;
    endcase
  endfunction

  function automatic logic [31:0] bcd_of(input int idx);
    case (idx)
      0: return {20'd0, bcd0};
      1: return {20'd0, bcd1};
      2: return {12'd0, bcd2};
      default: return {16'd0, bcd3};
    endcase
  endfunction

  function automatic logic [31:0] dec_ref(input int v);
    logic [31:0] r;
    int x;
    r = 32'd0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One conversion; optionally holds out_ready low for 'hold' cycles in DONE.
  task automatic conv(input int idx, input logic [15:0] val, input logic [31:0] exp,
                      input logic exp_sign, input int lat, input int hold);
    int cycles;
    logic [31:0] held;
    check($sformatf("i%0d ready_before", idx), {31'd0, ir_of(idx)}, 32'd1);
    set_in(idx, 1'b1, val);
    wait_clk();
    set_in(idx, 1'b0, 16'h0000);
    cycles = 0;
    while (!ov_of(idx) && cycles < 200) begin
      wait_clk();
      cycles++;
    end
    check($sformatf("i%0d latency %0h", idx, val), cycles, lat);
    check($sformatf("i%0d bcd %0h", idx, val), bcd_of(idx), exp);
    check($sformatf("i%0d sign %0h", idx, val), {31'd0, sg_of(idx)}, {31'd0, exp_sign});
    held = bcd_of(idx);
    for (int k = 0; k < hold; k++) begin
      if (k == 1) set_in(idx, 1'b1, 16'h0011);
      wait_clk();
      set_in(idx, 1'b0, 16'h0000);
      check("bp bcd_stable", bcd_of(idx), held);
      check("bp in_ready_low", {31'd0, ir_of(idx)}, 32'd0);
      check("bp out_valid_high", {31'd0, ov_of(idx)}, 32'd1);
    end
    set_ordy(idx, 1'b1);
    wait_clk();
    set_ordy(idx, 1'b0);
    check($sformatf("i%0d out_valid_after_hs", idx), {31'd0, ov_of(idx)}, 32'd0);
    check($sformatf("i%0d in_ready_after_hs", idx), {31'd0, ir_of(idx)}, 32'd1);
    if (hold > 0) begin
      repeat (12) wait_clk();
      check("bp no_ghost_conversion", {31'd0, ov_of(idx)}, 32'd0);
    end
  endtask

  logic [31:0] exp_q[$];
  int received;

  initial begin
    int seen_ov;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(i, 1'b0, 16'h0000);
      set_ordy(i, 1'b0);
    end
    wait_clk();
    check("reset in_ready", {31'd0, ir0}, 32'd1);
    check("reset out_valid", {31'd0, ov0}, 32'd0);
    check("reset bcd", {20'd0, bcd0}, 32'd0);
    check("reset sign", {31'd0, sg1}, 32'd0);
    wait_clk();
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk();

    conv(0, 16'd255,  32'h255,   1'b0, 8,  0);
    conv(0, 16'd0,    32'h000,   1'b0, 8,  0);
    conv(0, 16'd128,  32'h128,   1'b0, 8,  0);
    conv(1, 16'h0080, 32'h128,   1'b1, 8,  0);
    conv(1, 16'h00FF, 32'h001,   1'b1, 8,  0);
    conv(1, 16'h007F, 32'h127,   1'b0, 8,  0);
    conv(1, 16'h0000, 32'h000,   1'b0, 8,  0);
    conv(1, 16'h009C, 32'h100,   1'b1, 8,  0);
    conv(2, 16'd65535, 32'h65535, 1'b0, 16, 0);
    conv(2, 16'd10000, 32'h10000, 1'b0, 16, 0);
    conv(3, 16'd4095, 32'h4095,  1'b0, 12, 0);
    conv(0, 16'd200,  32'h200,   1'b0, 8,  5);

    // Abort mid-conversion with asynchronous reset after three iterations.
    set_in(0, 1'b1, 16'd255);
    wait_clk();
    set_in(0, 1'b0, 16'h0000);
    repeat (3) wait_clk();
    rst_n = 1'b0;
    #1;
    check("abort in_ready", {31'd0, ir0}, 32'd1);
    check("abort out_valid", {31'd0, ov0}, 32'd0);
    check("abort bcd", {20'd0, bcd0}, 32'd0);
    check("abort sign", {31'd0, sg0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_ov = 0;
    for (int k = 0; k < 30; k++) begin
      wait_clk();
      if (ov0) seen_ov++;
    end
    check("abort no_spurious_valid", seen_ov, 0);
    check("abort in_ready_after", {31'd0, ir0}, 32'd1);

    // Random sweep on the 12-bit instance with gaps on both sides.
    received = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int v;
          int to;
          logic acc;
          v = int'($urandom_range(0, 4095));
          repeat ($urandom_range(0, 2)) wait_clk();
          set_in(3, 1'b1, 16'(v));
          acc = 1'b0;
          to = 0;
          while (!acc && to < 2000) begin
            acc = ir3;
            wait_clk();
            to++;
          end
          set_in(3, 1'b0, 16'h0000);
          if (acc) exp_q.push_back(dec_ref(v));
        end
      end
      begin
        int guard;
        logic fire;
        guard = 0;
        while (received < 1000 && guard < 60000) begin
          set_ordy(3, 1'($urandom_range(0, 1)));
          fire = ov3 & or3;
          wait_clk();
          guard++;
          if (fire) begin
            received++;
            if (exp_q.size() > 0) begin
              check("sweep value", {16'd0, bcd3}, exp_q.pop_front());
            end else begin
              check("sweep unexpected_output", 32'd1, 32'd0);
            end
          end
        end
        set_ordy(3, 1'b0);
      end
    join
    check("sweep received_count", received, 1000);
    check("sweep queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
